mdio_master: RTL and testbench

//  Clause-22 MDIO/SMI management initiator for the RGMII Ethernet PHY. Serialises one read or write frame per request on MDC/MDIO.

---
 rtl/mdio_master_pkg.sv | 46 ++++
 rtl/mdio_clk_gen.sv | 36 +++
 rtl/mdio_master.sv | 150 +++++++++++++++
 tb/tb_mdio_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_master_pkg.sv
// Shared constants, FSM state type and frame builder for the
// clause-22 MDIO management initiator.
package mdio_master_pkg;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam int MDIO_PRE_BITS   = 32;
    localparam int MDIO_FRAME_BITS = 64;

    // Absolute bit index of the last bit of each frame field.
    localparam logic [5:0] BIT_PRE_END = 6'(MDIO_PRE_BITS - 1);
    localparam logic [5:0] BIT_HDR_END = 6'(MDIO_PRE_BITS + 13);
    localparam logic [5:0] BIT_TA_END  = 6'(MDIO_PRE_BITS + 15);
    localparam logic [5:0] BIT_LAST    = 6'(MDIO_FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_FIN
    } mdio_state_t;

    // Full 64-bit frame, MSB sent first. On reads the TA and data
    // positions are never driven, so they are filled with idle ones.
    function automatic logic [63:0] build_frame(
        input logic        rd,
        input logic [4:0]  pa,
        input logic [4:0]  ra,
        input logic [15:0] wd
    );
        logic [1:0]  op;
        logic [1:0]  ta;
        logic [15:0] dat;
        op  = rd ? MDIO_OP_RD : MDIO_OP_WR;
        ta  = rd ? 2'b11 : MDIO_TA_WR;
        dat = rd ? 16'hFFFF : wd;
        build_frame = {{MDIO_PRE_BITS{1'b1}}, MDIO_ST, op,
                       pa, ra, ta, dat};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: mdc low CLK_DIV cycles, high CLK_DIV cycles.
// Ports: clk, reset, run (hold mdc=0 while low), mdc,
//        mdc_rise / mdc_fall (high on the cycle before mdc changes).
module mdio_clk_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= RELOAD;
            mdc <= 1'b0;
        end else if (cnt == 8'd0) begin
            cnt <= RELOAD;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    // Look-ahead strobes let the frame logic update its registers
    // on the very edge where mdc toggles.
    assign mdc_rise = run && !mdc && (cnt == 8'd0);
    assign mdc_fall = run &&  mdc && (cnt == 8'd0);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO initiator: one read or write frame per start.
// Ports: clk, reset, start, op_read, phy_addr, reg_addr, wdata,
//        busy, done, rdata, mdc, mdio_o, mdio_oe, mdio_i,
//        rd_err (only when MDIO_RD_ERR_EN is defined).
module mdio_master
    import mdio_master_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_read,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
`ifdef MDIO_RD_ERR_EN
    output logic        rd_err,
`endif
    input  logic        mdio_i
);

    mdio_state_t state;
    logic [5:0]  bit_cnt;
    logic [63:0] tx_sh;
    logic [15:0] rx_sh;
    logic        op_rd_q;
    logic        mdio_meta;
    logic        mdio_s;
    logic [63:0] frame_d;
    logic        mdc_rise;
    logic        mdc_fall;
`ifdef MDIO_RD_ERR_EN
    logic        ta_q;
`endif

    assign frame_d = build_frame(op_read, phy_addr,
                                 reg_addr, wdata);

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (busy),
        .mdc      (mdc),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall)
    );

    // mdio_i is asynchronous; the bus idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdio_meta <= 1'b1;
            mdio_s    <= 1'b1;
        end else begin
            mdio_meta <= mdio_i;
            mdio_s    <= mdio_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 16'h0000;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
            bit_cnt <= 6'd0;
            tx_sh   <= 64'd0;
            rx_sh   <= 16'h0000;
            op_rd_q <= 1'b0;
`ifdef MDIO_RD_ERR_EN
            rd_err  <= 1'b0;
            ta_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE, S_FIN: begin
                    state <= S_IDLE;
                    if (start) begin
                        state   <= S_PRE;
                        busy    <= 1'b1;
                        op_rd_q <= op_read;
                        bit_cnt <= 6'd0;
                        mdio_o  <= frame_d[63];
                        mdio_oe <= 1'b1;
                        tx_sh   <= {frame_d[62:0], 1'b1};
`ifdef MDIO_RD_ERR_EN
                        ta_q    <= 1'b0;
`endif
                    end
                end
                S_PRE, S_HDR, S_TA, S_DATA: begin
                    if (mdc_rise) begin
                        if (state == S_DATA)
                            rx_sh <= {rx_sh[14:0], mdio_s};
`ifdef MDIO_RD_ERR_EN
                        // Second TA bit: a PHY that answers pulls it low.
                        if (state == S_TA &&
                            bit_cnt == BIT_TA_END)
                            ta_q <= mdio_s;
`endif
                    end
                    if (mdc_fall) begin
                        if (bit_cnt == BIT_LAST) begin
                            state   <= S_FIN;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            mdio_o  <= 1'b1;
                            mdio_oe <= 1'b0;
                            if (op_rd_q)
                                rdata <= rx_sh;
`ifdef MDIO_RD_ERR_EN
                            rd_err  <= op_rd_q & ta_q;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            mdio_o  <= tx_sh[63];
                            tx_sh   <= {tx_sh[62:0], 1'b1};
                            if (bit_cnt == BIT_PRE_END)
                                state <= S_HDR;
                            if (bit_cnt == BIT_HDR_END) begin
                                state <= S_TA;
                                // Hand the bus to the PHY for TA.
                                if (op_rd_q)
                                    mdio_oe <= 1'b0;
                            end
                            if (bit_cnt == BIT_TA_END)
                                state <= S_DATA;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: directed frame table,
// start-while-busy, mid-frame reset and back-to-back CLK_DIV=2.
module tb_mdio_master;

    localparam int D     = 10;
    localparam int D2    = 2;
    localparam int LIMIT = 1 + 128 * D + 50;
    localparam logic [63:0] RD_MASK = 64'hFFFFFFFF_FFFC0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op_read;
    logic [4:0]  phy_addr;
    logic [4:0]  reg_addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;
    logic        rd_err;
    logic        phy_en;
    logic        phy_val;

    logic        start2;
    logic        op2;
    logic [4:0]  phy2;
    logic [4:0]  reg2;
    logic [15:0] wd2;
    logic        busy2;
    logic        done2;
    logic [15:0] rdata2;
    logic        mdc2;
    logic        mdio_o2;
    logic        mdio_oe2;
    logic        mdio_i2;
    logic        rd_err2;

    int n_chk;
    int n_err;

    // Open-drain style bus with pull-up; PHY model drives when enabled.
    assign mdio_i  = mdio_oe ? mdio_o : (phy_en ? phy_val : 1'b1);
    assign mdio_i2 = mdio_oe2 ? mdio_o2 : 1'b1;

`ifndef MDIO_RD_ERR_EN
    assign rd_err  = 1'b0;
    assign rd_err2 = 1'b0;
`endif

    mdio_master #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_read  (op_read),
        .phy_addr (phy_addr),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .mdc      (mdc),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
`ifdef MDIO_RD_ERR_EN
        .rd_err   (rd_err),
`endif
        .mdio_i   (mdio_i)
    );

    mdio_master #(.CLK_DIV(D2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .op_read  (op2),
        .phy_addr (phy2),
        .reg_addr (reg2),
        .wdata    (wd2),
        .busy     (busy2),
        .done     (done2),
        .rdata    (rdata2),
        .mdc      (mdc2),
        .mdio_o   (mdio_o2),
        .mdio_oe  (mdio_oe2),
`ifdef MDIO_RD_ERR_EN
        .rd_err   (rd_err2),
`endif
        .mdio_i   (mdio_i2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        logic        phy_on;
        logic [15:0] pdat;
        logic [63:0] exp_frame;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Runs one frame on dut; called and returns at a negedge.
    task automatic run_frame(input vec_t v, input int poke_bit);
        int          cyc;
        int          k;
        logic        prev;
        bit          poked;
        logic [63:0] cap_o;
        logic [63:0] cap_oe;
        logic [63:0] mask;
        logic [63:0] exp_oe;
        cap_o    = '0;
        cap_oe   = '0;
        poked    = 1'b0;
        op_read  = v.op;
        phy_addr = v.phy;
        reg_addr = v.rg;
        wdata    = v.wd;
        phy_en   = 1'b0;
        phy_val  = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        k     = 0;
        prev  = mdc;
        chk("busy_rise", 64'(busy), 64'd1);
        while (!done && cyc < LIMIT) begin
            if (mdc && !prev) begin
                if (k < 64) begin
                    cap_o[63-k]  = mdio_o;
                    cap_oe[63-k] = mdio_oe;
                end
                k++;
            end
            if (!mdc && prev && v.phy_on) begin
                if (k == 47) begin
                    phy_en  = 1'b1;
                    phy_val = 1'b0;
                end else if (k >= 48 && k < 64) begin
                    phy_en  = 1'b1;
                    phy_val = v.pdat[63-k];
                end else begin
                    phy_en = 1'b0;
                end
            end
            if (poke_bit >= 0 && k == poke_bit && !poked) begin
                poked    = 1'b1;
                start    = 1'b1;
                op_read  = ~v.op;
                phy_addr = ~v.phy;
                reg_addr = ~v.rg;
                wdata    = ~v.wd;
            end else begin
                start = 1'b0;
            end
            prev = mdc;
            @(negedge clk);
            cyc++;
        end
        start  = 1'b0;
        phy_en = 1'b0;
        mask   = v.op ? RD_MASK : '1;
        exp_oe = v.op ? RD_MASK : '1;
        chk("done_seen", 64'(done), 64'd1);
        chk("latency", 64'(cyc), 64'(1 + 128 * D));
        chk("bit_count", 64'(k), 64'd64);
        chk("frame_bits", cap_o & mask, v.exp_frame & mask);
        chk("oe_pattern", cap_oe, exp_oe);
        chk("fin_busy", 64'(busy), 64'd0);
        chk("fin_oe_mdc", {62'd0, mdio_oe, mdc}, 64'd0);
        if (v.op)
            chk("rdata", 64'(rdata), 64'(v.exp_rd));
`ifdef MDIO_RD_ERR_EN
        chk("rd_err", 64'(rd_err), 64'(v.exp_err));
`endif
        @(negedge clk);
        chk("done_single", 64'(done), 64'd0);
    endtask

    initial begin : main
        int          cyc;
        int          k;
        int          dn;
        int          nb;
        int          rises;
        int          bad_per;
        int          gap;
        int          t_last;
        int          t_done1;
        int          t_done2;
        logic        prev;
        logic [63:0] cap2;

        n_chk = 0;
        n_err = 0;

        vecs[0] = '{1'b0, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000,
                    64'hFFFFFFFF_5082_1140, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h0022,
                    64'hFFFFFFFF_6088_0000, 16'h0022, 1'b0};
        vecs[2] = '{1'b1, 5'h03, 5'h01, 16'h0000, 1'b0, 16'h0000,
                    64'hFFFFFFFF_6184_0000, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b1, 5'h1E, 5'h11, 16'h0000, 1'b1, 16'hBEEF,
                    64'hFFFFFFFF_6F44_0000, 16'hBEEF, 1'b0};
        vecs[4] = '{1'b1, 5'h00, 5'h1F, 16'h0000, 1'b0, 16'h0000,
                    64'hFFFFFFFF_607C_0000, 16'hFFFF, 1'b1};
        vecs[5] = '{1'b0, 5'h1F, 5'h1F, 16'hA55A, 1'b0, 16'h0000,
                    64'hFFFFFFFF_5FFE_A55A, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 5'h12, 5'h0D, 16'h0000, 1'b0, 16'h0000,
                    64'hFFFFFFFF_5936_0000, 16'h0000, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        op_read  = 1'b0;
        phy_addr = '0;
        reg_addr = '0;
        wdata    = '0;
        phy_en   = 1'b0;
        phy_val  = 1'b1;
        start2   = 1'b0;
        op2      = 1'b0;
        phy2     = '0;
        reg2     = '0;
        wd2      = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_mdc", 64'(mdc), 64'd0);
        chk("rst_mdio_o", 64'(mdio_o), 64'd1);
        chk("rst_mdio_oe", 64'(mdio_oe), 64'd0);
        chk("rst_rd_err", 64'(rd_err), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_frame(vecs[i], -1);

        // Start pulsed mid-frame with different fields is ignored.
        run_frame(vecs[0], 20);
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) nb++;
        end
        chk("poke_no_second", 64'(nb), 64'd0);

        // Reset in the middle of a read.
        op_read  = 1'b1;
        phy_addr = 5'h01;
        reg_addr = 5'h02;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 0;
        cyc   = 0;
        prev  = mdc;
        while (k < 41 && cyc < LIMIT) begin
            if (mdc && !prev) k++;
            prev = mdc;
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_bit40", 64'(k), 64'd41);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_mdc", 64'(mdc), 64'd0);
        chk("abort_oe", 64'(mdio_oe), 64'd0);
        chk("abort_rdata", 64'(rdata), 64'd0);
        dn = 0;
        repeat (40) begin
            if (done || busy) dn++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(dn), 64'd0);
        run_frame(vecs[0], -1);

        // CLK_DIV=2 back-to-back writes, second start on FIN.
        op2     = 1'b0;
        phy2    = 5'h01;
        reg2    = 5'h00;
        wd2     = 16'h1140;
        start2  = 1'b1;
        @(negedge clk);
        start2  = 1'b0;
        cyc     = 1;
        dn      = 0;
        rises   = 0;
        bad_per = 0;
        gap     = 0;
        t_last  = -1;
        t_done1 = 0;
        t_done2 = 0;
        cap2    = '0;
        prev    = mdc2;
        while (dn < 2 && cyc < 1000) begin
            if (mdc2 && !prev) begin
                if (t_last >= 0) begin
                    if (rises == 64)
                        gap = cyc - t_last;
                    else if (cyc - t_last != 2 * D2)
                        bad_per++;
                end
                if (rises >= 64 && rises < 128)
                    cap2[127-rises] = mdio_o2;
                t_last = cyc;
                rises++;
            end
            if (done2) begin
                dn++;
                if (dn == 1) begin
                    t_done1 = cyc;
                    start2  = 1'b1;
                    phy2    = 5'h12;
                    reg2    = 5'h0D;
                    wd2     = 16'h0000;
                end else begin
                    t_done2 = cyc;
                end
            end else begin
                start2 = 1'b0;
            end
            prev = mdc2;
            @(negedge clk);
            cyc++;
        end
        start2 = 1'b0;
        chk("b2b_done1", 64'(t_done1), 64'(1 + 128 * D2));
        chk("b2b_done2", 64'(t_done2 - t_done1),
            64'(1 + 128 * D2));
        chk("b2b_rises", 64'(rises), 64'd128);
        chk("b2b_period", 64'(bad_per), 64'd0);
        chk("b2b_gap", 64'(gap), 64'(2 * D2 + 1));
        chk("b2b_frame2", cap2, 64'hFFFFFFFF_5936_0000);
        chk("b2b_idle", 64'(busy2), 64'd0);
        chk("b2b_rdata", 64'(rdata2), 64'd0);
        chk("b2b_rd_err", 64'(rd_err2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
